// File: rtl/multi_mode_reduce_unit.sv
// multi_mode_reduce_unit: per-chain vector reduction (pass, sum, signed max/min, frame accumulate)
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   valid_in, eof_in       beat valid, last beat of a frame
//   chainId_in             chain owning the current beat
//   tracing                1 = process data, 0 = accept configuration writes
//   configId, configData   configuration address and payload
//   vector_in              N lanes of DATA_WIDTH bits, lane 0 in the low bits
//   valid_out, vector_out  registered result, one cycle after the beat
module multi_mode_reduce_unit #(
   parameter int N                  = 8,
   parameter int DATA_WIDTH         = 32,
   parameter int MAX_CHAINS         = 4,
   parameter int PERSONAL_CONFIG_ID = 0,
   localparam int CW = MAX_CHAINS > 1 ? $clog2(MAX_CHAINS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      valid_in,
   input  logic                      eof_in,
   input  logic [CW-1:0]             chainId_in,
   input  logic                      tracing,
   input  logic [7:0]                configId,
   input  logic [7:0]                configData,
   input  logic [N*DATA_WIDTH-1:0]   vector_in,
   output logic                      valid_out,
   output logic [N*DATA_WIDTH-1:0]   vector_out
);
   localparam int DW = DATA_WIDTH;
   logic [7:0]    mode [MAX_CHAINS];
   logic [DW-1:0] acc  [MAX_CHAINS];
   logic [DW-1:0] sum, mx, mn, r0, acc_sel;
   logic [2:0]    m;
   logic          in_rng, pass, fire, cfg_hit;
   logic [CW-1:0] cidx;
   logic          unused_mode_hi;
   // out-of-range chains behave as pass-through and never index the state arrays
   assign in_rng  = {1'b0, chainId_in} < (CW+1)'(MAX_CHAINS);
   assign m       = in_rng ? mode[chainId_in][2:0] : 3'd0;
   assign acc_sel = in_rng ? acc[chainId_in] : '0;
   assign pass    = m == 3'd0 || m > 3'd4;
   assign fire    = tracing && valid_in && (m != 3'd4 || eof_in);
   assign cfg_hit = int'(configId) >= PERSONAL_CONFIG_ID && int'(configId) < PERSONAL_CONFIG_ID + MAX_CHAINS;
   assign cidx    = CW'(int'(configId) - PERSONAL_CONFIG_ID);
   // upper mode bits are stored but carry no meaning
   assign unused_mode_hi = ^mode[0][7:3];
   always_comb begin
      sum = '0;
      mx  = vector_in[DW-1:0];
      mn  = vector_in[DW-1:0];
      for (int i = 0; i < N; i++) begin
         sum = sum + vector_in[i*DW +: DW];
         mx  = $signed(vector_in[i*DW +: DW]) > $signed(mx) ? vector_in[i*DW +: DW] : mx;
         mn  = $signed(vector_in[i*DW +: DW]) < $signed(mn) ? vector_in[i*DW +: DW] : mn;
      end
      r0 = m == 3'd1 ? sum : m == 3'd2 ? mx : m == 3'd3 ? mn : acc_sel + sum;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out  <= 1'b0;
         vector_out <= '0;
         for (int c = 0; c < MAX_CHAINS; c++) begin
            mode[c] <= '0;
            acc[c]  <= '0;
         end
      end else begin
         valid_out <= fire;
         if (fire) vector_out <= pass ? vector_in : (N*DW)'(r0);
         if (tracing && valid_in && m == 3'd4) acc[chainId_in] <= eof_in ? '0 : acc_sel + sum;
         if (!tracing && cfg_hit) begin
            mode[cidx] <= configData;
            acc[cidx]  <= '0;
         end
      end
   end
endmodule

// File: tb/tb_multi_mode_reduce_unit.sv
// tb_multi_mode_reduce_unit: directed checks of every reduction mode, config decode and reset
module tb_multi_mode_reduce_unit;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         valid_in = 1'b0;
   logic         eof_in = 1'b0;
   logic [1:0]   chainId_in = '0;
   logic         tracing = 1'b0;
   logic [7:0]   configId = 8'hFF;
   logic [7:0]   configData = '0;
   logic [255:0] vector_in = '0;
   logic         valid_out;
   logic [255:0] vector_out;
   int total = 0;
   int bad = 0;
   logic [255:0] seq, v;

   multi_mode_reduce_unit dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .eof_in(eof_in),
      .chainId_in(chainId_in), .tracing(tracing), .configId(configId),
      .configData(configData), .vector_in(vector_in),
      .valid_out(valid_out), .vector_out(vector_out)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
      return {32'(a7), 32'(a6), 32'(a5), 32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
   endfunction

   function automatic logic [255:0] r0(input logic [31:0] x);
      return {224'd0, x};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [1:0] ch, input logic [255:0] d, input logic e);
      tracing = 1'b1;
      valid_in = 1'b1;
      eof_in = e;
      chainId_in = ch;
      vector_in = d;
      step();
      valid_in = 1'b0;
      eof_in = 1'b0;
   endtask

   task automatic cfg(input logic [7:0] id, input logic [7:0] d);
      tracing = 1'b0;
      valid_in = 1'b0;
      configId = id;
      configData = d;
      step();
      tracing = 1'b1;
      configId = 8'hFF;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      total++;
      if ({valid_out, vector_out} !== 257'd0) begin
         bad++;
         $display("FAIL reset got=%h exp=0", {valid_out, vector_out});
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_pass();
      beat(0, seq, 0);
      total++;
      if ({valid_out, vector_out} !== {1'b1, seq}) begin
         bad++;
         $display("FAIL pass got=%h exp=%h", {valid_out, vector_out}, {1'b1, seq});
      end
      step();
      total++;
      if ({valid_out, vector_out} !== {1'b0, seq}) begin
         bad++;
         $display("FAIL idle_hold got=%h exp=%h", {valid_out, vector_out}, {1'b0, seq});
      end
   endtask

   task automatic test_sum();
      cfg(1, 1);
      beat(1, {8{32'h7FFFFFFF}}, 0);
      total++;
      if ({valid_out, vector_out} !== {1'b1, r0(32'hFFFFFFF8)}) begin
         bad++;
         $display("FAIL sum_wrap got=%h exp=%h", {valid_out, vector_out}, {1'b1, r0(32'hFFFFFFF8)});
      end
      beat(1, seq, 0);
      total++;
      if ({valid_out, vector_out} !== {1'b1, r0(36)}) begin
         bad++;
         $display("FAIL sum_seq got=%h exp=%h", {valid_out, vector_out}, {1'b1, r0(36)});
      end
   endtask

   task automatic test_back_to_back();
      cfg(2, 2);
      cfg(3, 3);
      beat(2, v, 0);
      total++;
      if ({valid_out, vector_out} !== {1'b1, r0(7)}) begin
         bad++;
         $display("FAIL max got=%h exp=%h", {valid_out, vector_out}, {1'b1, r0(7)});
      end
      beat(3, v, 0);
      total++;
      if ({valid_out, vector_out} !== {1'b1, r0(32'hFFFFFFF7)}) begin
         bad++;
         $display("FAIL min got=%h exp=%h", {valid_out, vector_out}, {1'b1, r0(32'hFFFFFFF7)});
      end
      beat(2, v, 0);
      total++;
      if ({valid_out, vector_out} !== {1'b1, r0(7)}) begin
         bad++;
         $display("FAIL max_again got=%h exp=%h", {valid_out, vector_out}, {1'b1, r0(7)});
      end
   endtask

   task automatic test_frame();
      cfg(0, 4);
      beat(0, r0(10), 0);
      total++;
      if ({valid_out, vector_out} !== {1'b0, r0(7)}) begin
         bad++;
         $display("FAIL frame_b1 got=%h exp=%h", {valid_out, vector_out}, {1'b0, r0(7)});
      end
      beat(0, r0(10), 0);
      total++;
      if ({valid_out, vector_out} !== {1'b0, r0(7)}) begin
         bad++;
         $display("FAIL frame_b2 got=%h exp=%h", {valid_out, vector_out}, {1'b0, r0(7)});
      end
      beat(0, mk(1, 2, 3, 4, 0, 0, 0, 0), 1);
      total++;
      if ({valid_out, vector_out} !== {1'b1, r0(30)}) begin
         bad++;
         $display("FAIL frame_eof got=%h exp=%h", {valid_out, vector_out}, {1'b1, r0(30)});
      end
      beat(0, mk(1, -1, 2, 0, 0, 0, 0, 2), 1);
      total++;
      if ({valid_out, vector_out} !== {1'b1, r0(4)}) begin
         bad++;
         $display("FAIL frame_single got=%h exp=%h", {valid_out, vector_out}, {1'b1, r0(4)});
      end
   endtask

   task automatic test_interleave();
      beat(0, r0(3), 0);
      total++;
      if ({valid_out, vector_out} !== {1'b0, r0(4)}) begin
         bad++;
         $display("FAIL ilv_acc got=%h exp=%h", {valid_out, vector_out}, {1'b0, r0(4)});
      end
      beat(1, seq, 0);
      total++;
      if ({valid_out, vector_out} !== {1'b1, r0(36)}) begin
         bad++;
         $display("FAIL ilv_sum got=%h exp=%h", {valid_out, vector_out}, {1'b1, r0(36)});
      end
      beat(0, r0(2), 1);
      total++;
      if ({valid_out, vector_out} !== {1'b1, r0(5)}) begin
         bad++;
         $display("FAIL ilv_eof got=%h exp=%h", {valid_out, vector_out}, {1'b1, r0(5)});
      end
   endtask

   task automatic test_tracing_drop();
      beat(0, r0(5), 0);
      tracing = 1'b0;
      valid_in = 1'b1;
      chainId_in = 1;
      vector_in = seq;
      step();
      valid_in = 1'b0;
      total++;
      if ({valid_out, vector_out} !== {1'b0, r0(5)}) begin
         bad++;
         $display("FAIL trace_off got=%h exp=%h", {valid_out, vector_out}, {1'b0, r0(5)});
      end
      beat(0, r0(4), 1);
      total++;
      if ({valid_out, vector_out} !== {1'b1, r0(9)}) begin
         bad++;
         $display("FAIL trace_resume got=%h exp=%h", {valid_out, vector_out}, {1'b1, r0(9)});
      end
      beat(0, r0(10), 0);
      cfg(0, 4);
      beat(0, r0(4), 1);
      total++;
      if ({valid_out, vector_out} !== {1'b1, r0(4)}) begin
         bad++;
         $display("FAIL cfg_clear got=%h exp=%h", {valid_out, vector_out}, {1'b1, r0(4)});
      end
   endtask

   task automatic test_bad_cfg();
      cfg(4, 1);
      beat(0, r0(6), 1);
      total++;
      if ({valid_out, vector_out} !== {1'b1, r0(6)}) begin
         bad++;
         $display("FAIL cfg_out_of_range got=%h exp=%h", {valid_out, vector_out}, {1'b1, r0(6)});
      end
      cfg(0, 8'h0D);
      beat(0, seq, 1);
      total++;
      if ({valid_out, vector_out} !== {1'b1, seq}) begin
         bad++;
         $display("FAIL mode5_pass got=%h exp=%h", {valid_out, vector_out}, {1'b1, seq});
      end
   endtask

   task automatic test_reset_midframe();
      cfg(0, 4);
      beat(0, r0(10), 0);
      beat(0, r0(10), 0);
      rst_n = 1'b0;
      #1;
      total++;
      if ({valid_out, vector_out} !== 257'd0) begin
         bad++;
         $display("FAIL async_reset got=%h exp=0", {valid_out, vector_out});
      end
      step();
      rst_n = 1'b1;
      beat(0, seq, 0);
      total++;
      if ({valid_out, vector_out} !== {1'b1, seq}) begin
         bad++;
         $display("FAIL rst_chain0 got=%h exp=%h", {valid_out, vector_out}, {1'b1, seq});
      end
      beat(1, seq, 0);
      total++;
      if ({valid_out, vector_out} !== {1'b1, seq}) begin
         bad++;
         $display("FAIL rst_chain1 got=%h exp=%h", {valid_out, vector_out}, {1'b1, seq});
      end
      beat(2, v, 0);
      total++;
      if ({valid_out, vector_out} !== {1'b1, v}) begin
         bad++;
         $display("FAIL rst_chain2 got=%h exp=%h", {valid_out, vector_out}, {1'b1, v});
      end
   endtask

   initial begin
      seq = mk(1, 2, 3, 4, 5, 6, 7, 8);
      v = mk(-5, 3, -9, 7, 0, 1, 2, -1);
      test_reset();
      test_pass();
      test_sum();
      test_back_to_back();
      test_frame();
      test_interleave();
      test_tracing_drop();
      test_bad_cfg();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
